odd_sweep_arbiter: RTL and testbench
====================================

ODD_SWEEP_ARBITER -- requirements
Module: odd_sweep_arbiter

Interface
REQ-001 Parameter IDX_W, default 3: width of the internal odd-value index; count width is IDX_W+1.
REQ-002 clk  input  1  single clock; all state updates on posedge clk.
REQ-003 reset  input  1  asynchronous active-low reset; asserting it (low) clears all state immediately, and release is sampled on clk.
REQ-004 req  input  2  per-requester sweep request; bit i held high by requester i until gnt[i] is seen.
REQ-005 dir  input  2  per-requester direction; 1 = up, 0 = down; sampled with the grant.
REQ-006 len0, len1  input  3 each  sweep length minus one (0..7 gives 1..8 steps); sampled with the grant.
REQ-007 gnt  output  2  one-hot, one-cycle grant pulse to the winning requester.
REQ-008 busy  output  1  high while a sweep is in RUN or DONE.
REQ-009 owner  output  1  index of the current or most recent grantee.
REQ-010 done  output  1  one-cycle pulse marking sweep completion.
REQ-011 count  output  IDX_W+1  current odd value, equal to {index, 1'b1} (1, 3, ..., 15 at default).

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-013 IDLE, req==0 -> stay in IDLE; gnt=0, index is held.
REQ-014 IDLE, req!=0 -> choose a winner, pulse gnt[winner] for 1 cycle, latch dir[winner], len_winner and owner, and go to RUN on the same edge.
REQ-015 Arbitration SHALL be round-robin: a single request wins; when both request, the requester not served last wins.
REQ-016 RUN SHALL step index by exactly one position per cycle, using +1 mod 2^IDX_W when the latched dir is up and -1 mod 2^IDX_W when it is down.
REQ-017 Wrap-around: index 7 up -> 0 (count 15 -> 1); index 0 down -> 7 (count 1 -> 15).
REQ-018 RUN SHALL last exactly len+1 cycles, using a step counter loaded from the latched len.
REQ-019 On the final step the FSM SHALL go to DONE.
REQ-020 DONE SHALL last 1 cycle with done=1 and index held, then return to IDLE.
REQ-021 gnt SHALL be zero outside the IDLE->RUN transition cycle.
REQ-022 Changes on req, dir or len during RUN or DONE SHALL be ignored.
REQ-023 A request pending at DONE SHALL be arbitrated in the next IDLE cycle, giving a minimum gap of 1 IDLE cycle between sweeps.
REQ-024 Index persists between sweeps; each new sweep starts from the last count value.
REQ-025 count SHALL be odd in every cycle, including during reset.

Reset
REQ-026 While reset=0, the block SHALL hold: state IDLE, index 0, count 1, gnt 0, busy 0, done 0, owner 0, step counter 0.
REQ-027 The round-robin pointer SHALL reset so that requester 0 wins the first simultaneous request.
REQ-028 Reset during RUN SHALL abort the sweep with no done pulse; after release, operation resumes from IDLE with count 1.

Structure
REQ-029 The state enum (IDLE/RUN/DONE) and the IDX_W default SHALL live in the shared package odd_counter_pkg.
REQ-030 The index register and its wrap logic SHALL be one sub-module, odd_step_core: inputs clk, reset, en, up; output count.
REQ-031 The FSM and arbiter SHALL remain in odd_sweep_arbiter.

Verification
REQ-032 Reset check: assert reset mid-RUN after 3 steps up from count 1 -> count=1, busy=0, no done; after release, IDLE.
REQ-033 Single sweep up: req=01, dir[0]=1, len0=3 -> gnt=01 for 1 cycle, then count 3,5,7,9 on successive cycles, then done pulse, busy falls after DONE.
REQ-034 Down with wrap: starting at count 3, req=10, dir[1]=0, len1=2 -> count 1,15,13, then done, owner=1.
REQ-035 Contention: req=11 after reset -> gnt=01 first; after DONE+1 IDLE cycle, gnt=10; on req=11 again, gnt=01.
REQ-036 Full-cycle wrap: len0=7 up from count 1 -> 8 steps ending at count 1.
REQ-037 Input stability: toggle dir and len during RUN -> step count and direction are unchanged.

Source files
------------

// File: rtl/odd_counter_pkg.sv
// Shared definitions for the odd-value sweep counter and its arbiter front end.
package odd_counter_pkg;

  localparam int unsigned IdxWDefault = 3;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

endpackage

// File: rtl/odd_step_core.sv
// Index register that walks up or down by one position per enabled cycle, wrapping mod 2^IDX_W.
// The exposed count is always the odd value {index, 1}.
module odd_step_core
  import odd_counter_pkg::*;
#(
  parameter int unsigned IDX_W = IdxWDefault
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up,
  output logic [IDX_W:0]   count
);

  localparam logic [IDX_W-1:0] One = 1;

  logic [IDX_W-1:0] index_q, index_d;

  always_comb begin
    index_d = index_q;
    if (en) begin
      // Natural overflow/underflow of the index gives the 15->1 and 1->15 wrap.
      index_d = up ? (index_q + One) : (index_q - One);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      index_q <= '0;
    end else begin
      index_q <= index_d;
    end
  end

  assign count = {index_q, 1'b1};

endmodule

// File: rtl/odd_sweep_arbiter.sv
// Two-requester round-robin arbiter that grants a fixed-length odd-value sweep,
// stepping the shared odd counter up or down once per RUN cycle.
module odd_sweep_arbiter
  import odd_counter_pkg::*;
#(
  parameter int unsigned IDX_W = IdxWDefault
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       req,
  input  logic [1:0]       dir,
  input  logic [2:0]       len0,
  input  logic [2:0]       len1,
  output logic [1:0]       gnt,
  output logic             busy,
  output logic             owner,
  output logic             done,
  output logic [IDX_W:0]   count
);

  state_e     state_q, state_d;
  logic       dir_q, dir_d;
  logic [2:0] step_q, step_d;
  logic       owner_q, owner_d;
  logic       last_q, last_d;
  logic       win;
  logic       step_en;

  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    step_d  = step_q;
    owner_d = owner_q;
    last_d  = last_q;
    win     = 1'b0;
    gnt     = '0;
    done    = 1'b0;
    step_en = 1'b0;
    unique case (state_q)
      StIdle: begin
        // Grant is combinational in IDLE, so keep it quiet while reset is held.
        if (reset && (req != 2'b00)) begin
          win      = (req == 2'b11) ? ~last_q : req[1];
          gnt[win] = 1'b1;
          dir_d    = dir[win];
          step_d   = win ? len1 : len0;
          owner_d  = win;
          last_d   = win;
          state_d  = StRun;
        end
      end
      StRun: begin
        step_en = 1'b1;
        if (step_q == 3'd0) begin
          state_d = StDone;
        end else begin
          step_d = step_q - 3'd1;
        end
      end
      StDone: begin
        done    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // last_q resets to 1 so requester 0 wins the first simultaneous request.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      dir_q   <= 1'b0;
      step_q  <= 3'd0;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      step_q  <= step_d;
      owner_q <= owner_d;
      last_q  <= last_d;
    end
  end

  assign busy  = (state_q != StIdle);
  assign owner = owner_q;

  odd_step_core #(
    .IDX_W(IDX_W)
  ) u_core (
    .clk  (clk),
    .reset(reset),
    .en   (step_en),
    .up   (dir_q),
    .count(count)
  );

endmodule

// File: tb/tb_odd_sweep_arbiter.sv
// Directed bench for odd_sweep_arbiter: reset, single sweeps, wrap, contention, input stability.
module tb_odd_sweep_arbiter;

  logic       clk;
  logic       reset;
  logic [1:0] req;
  logic [1:0] dir;
  logic [2:0] len0;
  logic [2:0] len1;
  logic [1:0] gnt;
  logic       busy;
  logic       owner;
  logic       done;
  logic [3:0] count;

  int total;
  int bad;

  odd_sweep_arbiter #(
    .IDX_W(3)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .req  (req),
    .dir  (dir),
    .len0 (len0),
    .len1 (len1),
    .gnt  (gnt),
    .busy (busy),
    .owner(owner),
    .done (done),
    .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int next_odd(input int c, input logic up);
    if (up) return (c == 15) ? 1 : c + 2;
    else    return (c == 1) ? 15 : c - 2;
  endfunction

  // Starts at a negedge in IDLE; ends at the negedge of the IDLE cycle after DONE.
  task automatic sweep(input logic [1:0] r, input logic [1:0] eg, input logic eo, input int n,
                       input int c0, input logic up, input logic tog);
    int c;
    req = r;
    #1;
    chk("grant", {6'd0, gnt}, {6'd0, eg});
    chk("busy_idle", {7'd0, busy}, 8'd0);
    @(negedge clk);
    chk("gnt_run", {6'd0, gnt}, 8'd0);
    chk("busy_run", {7'd0, busy}, 8'd1);
    chk("owner", {7'd0, owner}, {7'd0, eo});
    chk("count_start", {4'd0, count}, 8'(c0));
    req = r & ~eg;
    if (tog) begin
      dir  = ~dir;
      len0 = ~len0;
      len1 = ~len1;
    end
    c = c0;
    for (int k = 1; k < n; k++) begin
      @(negedge clk);
      c = next_odd(c, up);
      chk("count_step", {4'd0, count}, 8'(c));
      chk("done_run", {7'd0, done}, 8'd0);
      chk("gnt_quiet", {6'd0, gnt}, 8'd0);
    end
    @(negedge clk);
    c = next_odd(c, up);
    chk("count_done", {4'd0, count}, 8'(c));
    chk("done_pulse", {7'd0, done}, 8'd1);
    chk("busy_done", {7'd0, busy}, 8'd1);
    chk("gnt_done", {6'd0, gnt}, 8'd0);
    @(negedge clk);
    chk("done_clear", {7'd0, done}, 8'd0);
    chk("busy_clear", {7'd0, busy}, 8'd0);
    chk("count_hold", {4'd0, count}, 8'(c));
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b0;
    req   = 2'b00;
    dir   = 2'b00;
    len0  = 3'd0;
    len1  = 3'd0;

    // Reset values, with a request present that must not be granted.
    #2;
    chk("rst_count", {4'd0, count}, 8'd1);
    chk("rst_busy", {7'd0, busy}, 8'd0);
    chk("rst_done", {7'd0, done}, 8'd0);
    chk("rst_owner", {7'd0, owner}, 8'd0);
    req = 2'b11;
    #1;
    chk("rst_gnt", {6'd0, gnt}, 8'd0);
    req = 2'b00;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("idle_busy", {7'd0, busy}, 8'd0);
    chk("idle_count", {4'd0, count}, 8'd1);

    // Reset in the middle of an up sweep after three steps.
    dir  = 2'b01;
    len0 = 3'd7;
    req  = 2'b01;
    #1;
    chk("mr_gnt", {6'd0, gnt}, 8'd1);
    @(negedge clk);
    req = 2'b00;
    repeat (3) @(negedge clk);
    chk("mr_count_pre", {4'd0, count}, 8'd7);
    #1 reset = 1'b0;
    #1;
    chk("mr_count", {4'd0, count}, 8'd1);
    chk("mr_busy", {7'd0, busy}, 8'd0);
    chk("mr_done", {7'd0, done}, 8'd0);
    @(negedge clk);
    chk("mr_done2", {7'd0, done}, 8'd0);
    reset = 1'b1;
    @(negedge clk);
    chk("mr_idle_busy", {7'd0, busy}, 8'd0);
    chk("mr_idle_count", {4'd0, count}, 8'd1);
    chk("mr_idle_done", {7'd0, done}, 8'd0);

    // Contention: requester 0 first, then requester 1 down with wrap, then 0 again.
    dir  = 2'b01;
    len0 = 3'd0;
    len1 = 3'd2;
    sweep(2'b11, 2'b01, 1'b0, 1, 1, 1'b1, 1'b0);
    sweep(2'b10, 2'b10, 1'b1, 3, 3, 1'b0, 1'b0);
    dir  = 2'b01;
    len0 = 3'd1;
    sweep(2'b11, 2'b01, 1'b0, 2, 13, 1'b1, 1'b0);
    req = 2'b00;

    // Full-cycle wrap: eight steps up from 1 lands back on 1.
    dir  = 2'b01;
    len0 = 3'd7;
    sweep(2'b01, 2'b01, 1'b0, 8, 1, 1'b1, 1'b0);

    // Single sweep up with dir/len toggled during RUN.
    dir  = 2'b01;
    len0 = 3'd3;
    sweep(2'b01, 2'b01, 1'b0, 4, 1, 1'b1, 1'b1);
    @(negedge clk);
    chk("final_count", {4'd0, count}, 8'd9);
    chk("final_busy", {7'd0, busy}, 8'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
